// File: rtl/vec_out_pkg.sv
// Shared types and lane-scan helpers for the vector output port.
package vec_out_pkg;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  // Helpers work on a fixed-width mask; callers zero-extend and truncate the index.
  localparam int MAX_LANES = 64;
  localparam int MAX_WL    = 6;

  typedef struct packed {
    logic              found;
    logic [MAX_WL-1:0] idx;
  } lsb_t;

  function automatic lsb_t lowest_set(input logic [MAX_LANES-1:0] m);
    lsb_t r;
    r = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (m[i]) begin
        r.found = 1'b1;
        r.idx   = MAX_WL'(i);
      end
    end
    return r;
  endfunction

  function automatic logic is_one_hot(input logic [MAX_LANES-1:0] m);
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/vec_sync_fifo.sv
// Synchronous FIFO with registered count; head entry is presented combinationally.
module vec_sync_fifo #(
  parameter int DSIZE = 272,
  parameter int ASIZE = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr, rptr;
  logic [ASIZE:0]   count;
  logic             push, pop;

  assign full  = (count == (ASIZE+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/vec_out_port.sv
// Buffers masked vectors from the core and serialises enabled lanes, lowest first,
// onto an N-bit valid/ready stream.
module vec_out_port
  import vec_out_pkg::*;
#(
  parameter int  WIDTH_VECTOR = 16,
  parameter int  N            = 16,
  parameter int  WA_FIFO      = 2,
  localparam int WL           = $clog2(WIDTH_VECTOR)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      vec_wr,
  input  logic [WIDTH_VECTOR*N-1:0] vec_wdata,
  input  logic [WIDTH_VECTOR-1:0]   vec_mask,
  output logic                      vec_full,
  output logic                      vec_empty,
  output logic                      overflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_data,
  output logic [WL-1:0]             out_lane,
  output logic                      out_last,
  output logic                      busy
);

  localparam int VW    = WIDTH_VECTOR * N;
  localparam int DSIZE = WIDTH_VECTOR + VW;

  function automatic logic [MAX_LANES-1:0] to_lanes(input logic [WIDTH_VECTOR-1:0] m);
    logic [MAX_LANES-1:0] r;
    r = '0;
    r[WIDTH_VECTOR-1:0] = m;
    return r;
  endfunction

  logic [DSIZE-1:0]        head;
  logic [WIDTH_VECTOR-1:0] head_mask;
  logic [VW-1:0]           head_data;
  logic                    fifo_rd;

  state_t                  state, nxt_state;
  logic [VW-1:0]           hold_data, nxt_hold;
  logic [WIDTH_VECTOR-1:0] rem_mask, nxt_mask, lane_bit;
  lsb_t                    cur_lo, nxt_lo;
  logic [WL-1:0]           cur_lane, nxt_lane;
  logic                    cur_last, nxt_send;
  logic                    unused_lsb;

  vec_sync_fifo #(.DSIZE(DSIZE), .ASIZE(WA_FIFO)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (vec_wr),
    .wdata ({vec_mask, vec_wdata}),
    .rd    (fifo_rd),
    .rdata (head),
    .full  (vec_full),
    .empty (vec_empty)
  );

  assign head_mask  = head[DSIZE-1 -: WIDTH_VECTOR];
  assign head_data  = head[VW-1:0];
  assign cur_lo     = lowest_set(to_lanes(rem_mask));
  assign cur_lane   = cur_lo.idx[WL-1:0];
  assign cur_last   = is_one_hot(to_lanes(rem_mask));
  assign nxt_lo     = lowest_set(to_lanes(nxt_mask));
  assign nxt_lane   = nxt_lo.idx[WL-1:0];
  assign nxt_send   = (nxt_state == ST_SEND) && nxt_lo.found;
  assign unused_lsb = ^{cur_lo, nxt_lo};
  assign busy       = !vec_empty || (state == ST_SEND);

  // Next-state: load from the buffer head when idle, or right after a last beat.
  always_comb begin
    nxt_state = state;
    nxt_hold  = hold_data;
    nxt_mask  = rem_mask;
    fifo_rd   = 1'b0;
    lane_bit  = '0;
    lane_bit[cur_lane] = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!vec_empty) begin
          fifo_rd   = 1'b1;
          nxt_hold  = head_data;
          nxt_mask  = head_mask;
          nxt_state = (|head_mask) ? ST_SEND : ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_ready && cur_lo.found) begin
          nxt_mask = rem_mask & ~lane_bit;
          if (cur_last) begin
            if (!vec_empty) begin
              fifo_rd   = 1'b1;
              nxt_hold  = head_data;
              nxt_mask  = head_mask;
              nxt_state = (|head_mask) ? ST_SEND : ST_IDLE;
            end else begin
              nxt_state = ST_IDLE;
            end
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Beat outputs are registered from the next holding contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hold_data <= '0;
      rem_mask  <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= nxt_state;
      hold_data <= nxt_hold;
      rem_mask  <= nxt_mask;
      out_valid <= nxt_send;
      out_lane  <= nxt_send ? nxt_lane : '0;
      out_data  <= nxt_send ? nxt_hold[nxt_lane*N +: N] : '0;
      out_last  <= nxt_send && is_one_hot(to_lanes(nxt_mask));
      if (vec_wr && vec_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_out_port.sv
// Directed bench for vec_out_port: single vector, stalls, back-to-back, zero mask,
// overflow and mid-operation reset.
module tb_vec_out_port;

  localparam int WV = 16;
  localparam int N  = 16;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vec_wr = 1'b0;
  logic [WV*N-1:0] vec_wdata = '0;
  logic [WV-1:0] vec_mask = '0;
  logic          vec_full, vec_empty, overflow;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic [WL-1:0] out_lane;
  logic          out_last, busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vec_out_port #(.WIDTH_VECTOR(WV), .N(N), .WA_FIFO(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .vec_wr    (vec_wr),
    .vec_wdata (vec_wdata),
    .vec_mask  (vec_mask),
    .vec_full  (vec_full),
    .vec_empty (vec_empty),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic beat(input string tag, input int lane, input logic [15:0] data, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lane"},  32'(out_lane),  32'(lane));
    chk({tag, "_data"},  32'(out_data),  32'(data));
    chk({tag, "_last"},  32'(out_last),  32'(last));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_full"},  32'(vec_full),  32'd0);
    chk({tag, "_empty"}, 32'(vec_empty), 32'd1);
    chk({tag, "_ovf"},   32'(overflow),  32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_lane"},  32'(out_lane),  32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  function automatic logic [WV*N-1:0] ramp(input logic [15:0] base);
    logic [WV*N-1:0] r;
    for (int i = 0; i < WV; i++) r[i*N +: N] = base + 16'(i);
    return r;
  endfunction

  // Drives one push for exactly one cycle.
  task automatic push(input logic [WV-1:0] mask, input logic [WV*N-1:0] data);
    vec_wr    = 1'b1;
    vec_mask  = mask;
    vec_wdata = data;
    step();
    vec_wr    = 1'b0;
  endtask

  initial begin
    int lanes [4];
    lanes = '{0, 5, 10, 15};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rstn = 1'b1;
    step();

    // Single vector, consumer always ready
    out_ready = 1'b1;
    push(16'h8421, ramp(16'h0100));
    chk("s1_lat1", 32'(out_valid), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      beat("s1_beat", lanes[k], 16'h0100 + 16'(lanes[k]), k == 3);
      step();
    end
    chk("s1_done", 32'(out_valid), 32'd0);
    chk("s1_busy", 32'(busy), 32'd0);

    // Same vector with three stall cycles per beat
    out_ready = 1'b0;
    push(16'h8421, ramp(16'h0100));
    step();
    for (int k = 0; k < 4; k++) begin
      beat("s2_beat", lanes[k], 16'h0100 + 16'(lanes[k]), k == 3);
      repeat (3) begin
        step();
        beat("s2_stall", lanes[k], 16'h0100 + 16'(lanes[k]), k == 3);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("s2_done", 32'(out_valid), 32'd0);
    chk("s2_busy", 32'(busy), 32'd0);

    // Back-to-back vectors with no gap between them
    out_ready = 1'b1;
    push(16'h0003, ramp(16'h0200));
    push(16'h0001, ramp(16'h0300));
    beat("s3_b0", 0, 16'h0200, 1'b0);
    step();
    beat("s3_b1", 1, 16'h0201, 1'b1);
    step();
    beat("s3_b2", 0, 16'h0300, 1'b1);
    step();
    chk("s3_done", 32'(out_valid), 32'd0);

    // Zero-mask entry is dropped silently
    push(16'h0000, ramp(16'h0900));
    push(16'h0010, ramp(16'h0440));
    chk("s4_gap", 32'(out_valid), 32'd0);
    step();
    beat("s4_b", 4, 16'h0444, 1'b1);
    step();
    chk("s4_done", 32'(out_valid), 32'd0);

    // Stalled consumer: first vector sits in the holding register, the next
    // four fill the buffer, the sixth push is dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push(16'(1) << k, ramp(16'h0500));
      chk("s5_full", 32'(vec_full), 32'(k >= 4));
      chk("s5_ovf",  32'(overflow), 32'(k == 5));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      beat("s5_drain", k, 16'h0500 + 16'(k), 1'b1);
      step();
    end
    chk("s5_done",  32'(out_valid), 32'd0);
    chk("s5_empty", 32'(vec_empty), 32'd1);
    chk("s5_ovf_sticky", 32'(overflow), 32'd1);

    // Reset during the second beat of a four-beat vector
    push(16'h8421, ramp(16'h0100));
    step();
    beat("s6_b0", 0, 16'h0100, 1'b0);
    step();
    beat("s6_b1", 5, 16'h0105, 1'b0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("s6_rst");
    repeat (2) step();
    check_reset_outputs("s6_hold");
    rstn = 1'b1;
    repeat (3) begin
      step();
      chk("s6_quiet", 32'(out_valid), 32'd0);
      chk("s6_idle",  32'(busy), 32'd0);
    end
    push(16'h0002, ramp(16'h0700));
    chk("s6_lat1", 32'(out_valid), 32'd0);
    step();
    beat("s6_new", 1, 16'h0701, 1'b1);
    step();
    chk("s6_done", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
